// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative multiply/divide unit.
//   - op encodings (OP_MULTU, OP_MULT, OP_DIVU, OP_DIV)
//   - FSM state type and state constants
//   - default operand/result width
package muldiv_pkg;

    localparam int DEFAULT_WIDTH = 32;

    // Operation select: op[1] = divide, op[0] = signed.
    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_RUN    = 2'd1;
    localparam state_t ST_FINISH = 2'd2;

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply / divide unit producing HI/LO results.
//
// One shift-add (multiply) or restoring shift-subtract (divide) step per
// cycle on operand magnitudes, followed by a sign-correction cycle.
// done rises WIDTH+1 edges after the edge that samples start.
//
// Handshake: start is sampled only in IDLE (busy low); a start seen while
// busy is high is dropped. done is a one-cycle pulse, and the cycle in
// which done is high is already IDLE, so a new start may be issued there.
//
// Configuration: define MULDIV_DIVIDE_EN to build the divide datapath.
// Without it, starts with op[1] = 1 are ignored and div_by_zero is 0.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high
//   start        request to begin an operation
//   op           00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   operand_a    multiplicand / dividend
//   operand_b    multiplier / divisor
//   busy         operation in progress
//   done         one-cycle completion pulse
//   hi           product upper half / remainder
//   lo           product lower half / quotient
//   div_by_zero  valid with done: divide had operand_b == 0
//   o_dbg_state  current FSM state
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero,
    output state_t           o_dbg_state
);

    localparam int CW = $clog2(WIDTH);

    state_t             r_state;
    logic [CW-1:0]      r_count;
    logic [WIDTH-1:0]   r_m;        // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   r_acc_hi;   // partial product high / remainder
    logic [WIDTH-1:0]   r_acc_lo;   // multiplier bits / dividend-quotient
    logic               r_neg_q;    // negate product or quotient
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_dbz_out;

    logic               w_accept;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_step_hi;
    logic [WIDTH-1:0]   w_step_lo;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    // Magnitudes: only signed ops (op[0]) fold negative operands.
    assign w_a_mag = (op[0] && operand_a[WIDTH-1]) ? -operand_a : operand_a;
    assign w_b_mag = (op[0] && operand_b[WIDTH-1]) ? -operand_b : operand_b;

    // Multiply step: conditionally add the multiplicand, then shift the
    // {acc_hi, acc_lo} pair right, consuming one multiplier bit from acc_lo.
    assign w_mul_sum  = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_m} : '0);
    assign w_prod     = {r_acc_hi, r_acc_lo};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;

`ifdef MULDIV_DIVIDE_EN
    logic               r_div;
    logic               r_neg_r;    // remainder follows the dividend sign
    logic               r_dbz;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_fit;

    assign w_accept = start && (r_state == ST_IDLE);

    // Restoring divide: since remainder < divisor, the shifted value is
    // below 2*divisor, so bit WIDTH of the difference is a clean borrow.
    assign w_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_m};
    assign w_fit   = ~w_diff[WIDTH];
`else
    assign w_accept = start && (r_state == ST_IDLE) && !op[1];
`endif

    always_comb begin
        w_step_hi = w_mul_sum[WIDTH:1];
        w_step_lo = {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
        w_res_hi  = w_prod_fix[2*WIDTH-1:WIDTH];
        w_res_lo  = w_prod_fix[WIDTH-1:0];
`ifdef MULDIV_DIVIDE_EN
        if (r_div) begin
            w_step_hi = w_fit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
            w_step_lo = {r_acc_lo[WIDTH-2:0], w_fit};
            // A zero divisor leaves |a| in the remainder, so the normal
            // remainder correction already restores operand_a.
            w_res_hi  = r_neg_r ? -r_acc_hi : r_acc_hi;
            w_res_lo  = r_dbz ? '1 : (r_neg_q ? -r_acc_lo : r_acc_lo);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_m       <= '0;
            r_acc_hi  <= '0;
            r_acc_lo  <= '0;
            r_neg_q   <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
            r_dbz_out <= 1'b0;
`ifdef MULDIV_DIVIDE_EN
            r_div     <= 1'b0;
            r_neg_r   <= 1'b0;
            r_dbz     <= 1'b0;
`endif
        end else begin
            r_done    <= 1'b0;
            r_dbz_out <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state  <= ST_RUN;
                        r_count  <= '0;
                        r_acc_hi <= '0;
                        r_neg_q  <= op[0] && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
`ifdef MULDIV_DIVIDE_EN
                        r_div    <= op[1];
                        r_neg_r  <= op[0] && operand_a[WIDTH-1];
                        r_dbz    <= op[1] && (operand_b == '0);
                        r_m      <= op[1] ? w_b_mag : w_a_mag;
                        r_acc_lo <= op[1] ? w_a_mag : w_b_mag;
`else
                        r_m      <= w_a_mag;
                        r_acc_lo <= w_b_mag;
`endif
                    end
                end
                ST_RUN: begin
                    r_acc_hi <= w_step_hi;
                    r_acc_lo <= w_step_lo;
                    r_count  <= r_count + 1'b1;
                    if (r_count == CW'(WIDTH-1)) begin
                        r_state <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    r_hi    <= w_res_hi;
                    r_lo    <= w_res_lo;
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
`ifdef MULDIV_DIVIDE_EN
                    r_dbz_out <= r_dbz;
`endif
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = (r_state != ST_IDLE);
    assign done        = r_done;
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign div_by_zero = r_dbz_out;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit (WIDTH = 32).
// Divide vectors are exercised when MULDIV_DIVIDE_EN is defined; otherwise
// the bench confirms that divide requests are ignored.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W       = 32;
    localparam int LATENCY = 33;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] operand_a = '0;
    logic [W-1:0] operand_b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div_by_zero;
    state_t       dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2*W-1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero),
        .o_dbg_state (dbg_state)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // ---------------- drivers ----------------
    // Call away from the rising edge; start is sampled on the next edge.
    task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        op        = o;
        operand_a = a;
        operand_b = b;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
    endtask

    // Counts rising edges until done is seen (sampled 1 unit after each edge).
    task automatic wait_done(output int edges);
        edges = 0;
        while (edges < 60) begin
            @(posedge clk);
            #1;
            edges++;
            if (done) break;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] e_hi, input logic [W-1:0] e_lo,
                          input logic e_dbz);
        int             edges;
        logic [2*W-1:0] exp;
        exp_q.push_back({e_hi, e_lo});
        @(negedge clk);
        launch(o, a, b);
        check({tag, "_busy_run"}, 64'(busy), 64'(1));
        wait_done(edges);
        check({tag, "_latency"}, 64'(edges), 64'(LATENCY));
        check({tag, "_busy_done"}, 64'(busy), 64'(0));
        exp = exp_q.pop_front();
        check({tag, "_hi"}, 64'(hi), 64'(exp[2*W-1:W]));
        check({tag, "_lo"}, 64'(lo), 64'(exp[W-1:0]));
        check({tag, "_dbz"}, 64'(div_by_zero), 64'(e_dbz));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int edges;
        int n_done;

        // Reset state
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_dbz", 64'(div_by_zero), 64'(0));
        check("rst_hi", 64'(hi), 64'(0));
        check("rst_lo", 64'(lo), 64'(0));
        check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        @(negedge clk);
        reset = 1'b0;

        // Multiply vectors
        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_op("multu_2p16", OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0);
        run_op("mult_minsq", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
        run_op("multu_zero", OP_MULTU, 32'h1234_5678, 32'd0, 32'd0, 32'd0, 1'b0);

`ifdef MULDIV_DIVIDE_EN
        run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
        run_op("divu_by0", OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
        // done and div_by_zero are single-cycle pulses
        @(posedge clk);
        #1;
        check("dbz_pulse_done", 64'(done), 64'(0));
        check("dbz_pulse_flag", 64'(div_by_zero), 64'(0));
        run_op("div_by0_neg", OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
`else
        // Divide requests are dropped; previous result (multu_zero) is held
        @(negedge clk);
        launch(OP_DIVU, 32'd100, 32'd7);
        check("nodiv_busy", 64'(busy), 64'(0));
        n_done = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        check("nodiv_no_done", 64'(n_done), 64'(0));
        check("nodiv_dbz", 64'(div_by_zero), 64'(0));
        check("nodiv_hi", 64'(hi), 64'(0));
        check("nodiv_lo", 64'(lo), 64'(0));
`endif

        // Start during RUN is ignored; back-to-back start in the done cycle
        @(negedge clk);
        launch(OP_MULTU, 32'd6, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        launch(OP_MULTU, 32'd3, 32'd3);
        check("ign_state", 64'(dbg_state), 64'(ST_RUN));
        wait_done(edges);
        check("ign_latency", 64'(edges), 64'(LATENCY - 10));
        check("ign_hi", 64'(hi), 64'(0));
        check("ign_lo", 64'(lo), 64'(42));
        launch(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        check("b2b_busy", 64'(busy), 64'(1));
        check("b2b_done_low", 64'(done), 64'(0));
        repeat (5) @(posedge clk);
        #1;
        check("b2b_hold_hi", 64'(hi), 64'(0));
        check("b2b_hold_lo", 64'(lo), 64'(42));
        wait_done(edges);
        check("b2b_latency", 64'(edges), 64'(LATENCY - 5));
        check("b2b_hi", 64'(hi), 64'hFFFF_FFFF);
        check("b2b_lo", 64'(lo), 64'hFFFF_FFEB);

        // Reset mid-RUN aborts without a done pulse
        @(negedge clk);
        launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_hi", 64'(hi), 64'(0));
        check("abort_lo", 64'(lo), 64'(0));
        check("abort_state", 64'(dbg_state), 64'(ST_IDLE));
        @(negedge clk);
        reset = 1'b0;
        n_done = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        check("abort_no_done", 64'(n_done), 64'(0));
        check("abort_idle_busy", 64'(busy), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand and result width in bits.
REQ-002 The block SHALL have input clk, 1 bit, system clock, rising-edge active.
REQ-003 The block SHALL have input reset, 1 bit, synchronous, active-high reset.
REQ-004 The block SHALL have input start, 1 bit, request to begin an operation.
REQ-005 The block SHALL have input op, 2 bits, operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 The block SHALL have input operand_a, WIDTH bits, rs value from the register file (multiplicand/dividend).
REQ-007 The block SHALL have input operand_b, WIDTH bits, rt value from the register file (multiplier/divisor).
REQ-008 The block SHALL have output busy, 1 bit, high while an operation is in progress.
REQ-009 The block SHALL have output done, 1 bit, one-cycle completion pulse.
REQ-010 The block SHALL have output hi, WIDTH bits, HI register (product upper half / remainder).
REQ-011 The block SHALL have output lo, WIDTH bits, LO register (product lower half / quotient).
REQ-012 The block SHALL have output div_by_zero, 1 bit, high together with done when a divide had operand_b == 0.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and FINISH.
REQ-014 In IDLE, a high start SHALL be accepted at that clock edge: operands and op latched, count = 0, next state RUN.
REQ-015 A start that arrives while busy is high SHALL be ignored, with no effect on state or outputs.
REQ-016 RUN SHALL perform one shift-add (multiply) or one restoring shift-subtract (divide) iteration per cycle on operand magnitudes.
REQ-017 RUN SHALL leave for FINISH at the edge where count == WIDTH-1.
REQ-018 FINISH SHALL apply sign correction, write hi/lo, and assert done for exactly one cycle, then return to IDLE.
REQ-019 Latency SHALL be fixed: done is high in the cycle after the 33rd rising edge following the start-sampling edge (WIDTH=32), independent of operand values.
REQ-020 busy SHALL be high from the start-sampling edge until the edge that raises done, and low while done is high.
REQ-021 Signed operations (MULT, DIV) SHALL apply these sign rules: product sign = sign(a) XOR sign(b); quotient sign = sign(a) XOR sign(b); remainder takes the sign of operand_a.
REQ-022 DIV of 0x80000000 by 0xFFFFFFFF SHALL yield lo = 0x80000000 and hi = 0, with no error flag.
REQ-023 A divide by zero SHALL run full latency and yield hi = operand_a, lo = all ones, div_by_zero = 1 for the done cycle.
REQ-024 hi and lo SHALL hold their values between completions; only FINISH updates them.
REQ-025 Back-to-back operation SHALL be supported: start is accepted in the IDLE cycle where done is high.
REQ-026 div_by_zero SHALL be 0 whenever done is 0.

Reset
REQ-027 When reset is high at a rising edge, the block SHALL enter IDLE with busy = 0, done = 0, div_by_zero = 0, hi = 0, lo = 0, count = 0.
REQ-028 Reset SHALL take priority over start and SHALL abort an in-progress operation with no done pulse.

Configuration
REQ-029 With macro MULDIV_DIVIDE_EN defined, all four ops SHALL be supported.
REQ-030 Without MULDIV_DIVIDE_EN, the divide datapath SHALL be absent, start with op[1] = 1 SHALL be ignored (busy stays 0, no done), and div_by_zero SHALL be tied to 0.

Structure
REQ-031 Package muldiv_pkg SHALL hold the op encodings (OP_MULTU, OP_MULT, OP_DIVU, OP_DIV), the FSM state typedef and the default WIDTH constant.
REQ-032 The design SHALL be a single module with no sub-module; sign correction and the iteration step SHALL stay inline.

Verification
REQ-033 The bench SHALL check MULTU a = 0xFFFFFFFF, b = 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001, done exactly 33 edges after start.
REQ-034 The bench SHALL check MULT a = 0xFFFFFFFD (-3), b = 7 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFEB (-21).
REQ-035 The bench SHALL check DIV a = -7, b = 2 -> lo = 0xFFFFFFFD (-3), hi = 0xFFFFFFFF (-1); DIVU 100/7 -> lo = 14, hi = 2.
REQ-036 The bench SHALL check DIVU a = 5, b = 0 -> hi = 5, lo = 0xFFFFFFFF, div_by_zero = 1 with done.
REQ-037 The bench SHALL check that start pulsed during RUN is ignored, that hi/lo keep the first result, and that a start in the done cycle yields a second done 33 edges later.
REQ-038 The bench SHALL check that reset asserted mid-RUN gives busy = 0, hi = lo = 0, and no done pulse on the following 40 cycles.
